rv32i_mem_port_arbiter: RTL and testbench

RV32I_MEM_PORT_ARBITER -- requirements
Module: rv32i_mem_port_arbiter

---
 rtl/rv32i_mem_port_arbiter_if.sv | 54 +++++
 rtl/rv32i_mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_rv32i_mem_port_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_mem_port_arbiter_if.sv
// Bundle of fetch-port, data-port, shared-memory-port and hazard signals
// around the rv32i memory port arbiter. The arbiter takes the slave view;
// the pipeline/memory environment takes the master view.
interface rv32i_mem_port_arbiter_if;
  // fetch stage port
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  // data stage port
  logic        dm_req_i;
  logic        dm_we_i;
  logic [3:0]  dm_be_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_gnt_o;
  logic        dm_rvalid_o;
  logic [31:0] dm_rdata_o;
  // shared memory port
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  // hazard unit
  logic        flush_i;
  logic        structural_hazard_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
    output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  flush_i,
    output structural_hazard_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
    input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output flush_i,
    input  structural_hazard_o
  );
endinterface

// File: rtl/rv32i_mem_port_arbiter.sv
// Arbiter sharing one memory port between the fetch and data stages of an
// rv32i pipeline. One transaction is outstanding at a time. Data wins a
// contested cycle unless fetch has lost STARVE_LIMIT contested rounds in a
// row. The request toward memory is raised in the same cycle the requester
// asks, so the memory-side request and attributes are combinational from
// the state and the requester inputs, and are forced low while in reset.
module rv32i_mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  rv32i_mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

  state_e      state_r;
  logic        owner_data_r;   // 1: data stage owns the port, 0: fetch
  logic [3:0]  starve_r;
  logic        drop_r;

  logic        any_req_s;
  logic        pick_data_s;
  logic        sel_data_s;
  logic        mem_req_raw_s;
  logic        mem_req_s;
  logic        gnt_s;
  logic        rsp_s;
  logic        fetch_busy_s;
  logic        drop_now_s;

  // Arbitration decision and memory-request qualification for this cycle
  always_comb begin
    any_req_s     = bus.if_req_i | bus.dm_req_i;
    pick_data_s   = bus.dm_req_i & ~(bus.if_req_i & (starve_r == LIMIT_C));
    sel_data_s    = owner_data_r;
    mem_req_raw_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        sel_data_s    = pick_data_s;
        mem_req_raw_s = any_req_s;
      end
      ST_REQ: begin
        sel_data_s    = owner_data_r;
        mem_req_raw_s = 1'b1;
      end
      ST_RESP: begin
        sel_data_s    = owner_data_r;
        mem_req_raw_s = 1'b0;
      end
      default: begin
        sel_data_s    = owner_data_r;
        mem_req_raw_s = 1'b0;
      end
    endcase
    mem_req_s    = rst_ni & mem_req_raw_s;
    gnt_s        = mem_req_s & bus.mem_gnt_i;
    rsp_s        = rst_ni & (state_r == ST_RESP) & bus.mem_rvalid_i;
    fetch_busy_s = ~owner_data_r & ((state_r == ST_REQ) | (state_r == ST_RESP));
    // a flush landing on the response cycle itself also hides that response
    drop_now_s   = drop_r | (bus.flush_i & fetch_busy_s);
  end

  assign bus.mem_req_o   = mem_req_s;
  assign bus.mem_we_o    = mem_req_s & sel_data_s & bus.dm_we_i;
  assign bus.mem_be_o    = mem_req_s ? (sel_data_s ? bus.dm_be_i : 4'hF) : 4'h0;
  assign bus.mem_addr_o  = mem_req_s ? (sel_data_s ? bus.dm_addr_i : bus.if_addr_i) : 32'h0;
  assign bus.mem_wdata_o = (mem_req_s & sel_data_s) ? bus.dm_wdata_i : 32'h0;

  assign bus.if_gnt_o    = gnt_s & ~sel_data_s;
  assign bus.dm_gnt_o    = gnt_s & sel_data_s;
  assign bus.if_rvalid_o = rsp_s & ~owner_data_r & ~drop_now_s;
  assign bus.dm_rvalid_o = rsp_s & owner_data_r;
  assign bus.if_rdata_o  = bus.if_rvalid_o ? bus.mem_rdata_i : 32'h0;
  assign bus.dm_rdata_o  = bus.dm_rvalid_o ? bus.mem_rdata_i : 32'h0;

  // the data stage is stalled from its request up to (not including) its response cycle
  assign bus.structural_hazard_o = rst_ni & bus.dm_req_i & ~(rsp_s & owner_data_r);

  // Transaction FSM, owner latch, fetch starvation counter and flush drop flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= ST_IDLE;
      owner_data_r <= 1'b0;
      starve_r     <= 4'd0;
      drop_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            owner_data_r <= pick_data_s;
            state_r      <= bus.mem_gnt_i ? ST_RESP : ST_REQ;
            if (pick_data_s) begin
              if (bus.if_req_i && (starve_r < LIMIT_C)) begin
                starve_r <= starve_r + 4'd1;
              end
            end else begin
              starve_r <= 4'd0;
            end
          end
        end
        ST_REQ: begin
          if (bus.mem_gnt_i) begin
            state_r <= ST_RESP;
          end
          if (fetch_busy_s && bus.flush_i) begin
            drop_r <= 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.mem_rvalid_i) begin
            state_r <= ST_IDLE;
            drop_r  <= 1'b0;
          end else if (fetch_busy_s && bus.flush_i) begin
            drop_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          drop_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mem_port_arbiter.sv
// Scoreboard bench for rv32i_mem_port_arbiter: directed requests push the
// expected grant/response sequence, a monitor pops it whenever the DUT
// raises a grant or response valid.
module tb_rv32i_mem_port_arbiter;

  localparam int K_IF_GNT = 0;
  localparam int K_DM_GNT = 1;
  localparam int K_IF_RV  = 2;
  localparam int K_DM_RV  = 3;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rv32i_mem_port_arbiter_if bus ();

  rv32i_mem_port_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  exp_t        sb[$];
  logic [31:0] fq[$];
  dreq_t       dq[$];

  int checks = 0;
  int errors = 0;

  // responder configuration
  logic        auto_en;
  int          gnt_wait;
  int          rv_wait;
  logic        man_rvalid;
  logic [31:0] man_rdata;

  function automatic logic [31:0] rdata_for(input logic [31:0] addr);
    if (addr == 32'h0000_0100) return 32'hDEAD_BEEF;
    return addr ^ 32'hA5A5_0000;
  endfunction

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, req);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [31:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic sb_take(input int kind, input logic [31:0] val);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got event %0d value %h want no event", kind, val);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.val !== val) begin
        errors++;
        $display("FAIL sb_event: got event %0d value %h want event %0d value %h",
                 kind, val, e.kind, e.val);
      end
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((sb.size() != 0 || fq.size() != 0 || dq.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_drain: got %0d events pending want 0", name, sb.size());
      sb.delete();
      fq.delete();
      dq.delete();
    end
    @(negedge clk);
  endtask

  // requester driver: fetch holds until its grant, data holds until its response
  initial begin
    logic f_taken;
    logic d_done;
    bus.if_req_i   = 1'b0;
    bus.if_addr_i  = 32'h0;
    bus.dm_req_i   = 1'b0;
    bus.dm_we_i    = 1'b0;
    bus.dm_be_i    = 4'h0;
    bus.dm_addr_i  = 32'h0;
    bus.dm_wdata_i = 32'h0;
    forever begin
      @(negedge clk);
      f_taken = bus.if_gnt_o;
      d_done  = bus.dm_rvalid_o;
      @(posedge clk);
      #1;
      if (f_taken && fq.size() > 0) void'(fq.pop_front());
      if (d_done && dq.size() > 0) void'(dq.pop_front());
      if (fq.size() > 0) begin
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = fq[0];
      end else begin
        bus.if_req_i  = 1'b0;
        bus.if_addr_i = 32'h0;
      end
      if (dq.size() > 0) begin
        bus.dm_req_i   = 1'b1;
        bus.dm_we_i    = dq[0].we;
        bus.dm_be_i    = dq[0].be;
        bus.dm_addr_i  = dq[0].addr;
        bus.dm_wdata_i = dq[0].wdata;
      end else begin
        bus.dm_req_i   = 1'b0;
        bus.dm_we_i    = 1'b0;
        bus.dm_be_i    = 4'h0;
        bus.dm_addr_i  = 32'h0;
        bus.dm_wdata_i = 32'h0;
      end
    end
  end

  // memory responder: grant after gnt_wait cycles, response rv_wait cycles after the grant
  initial begin
    logic        pend;
    logic        hs_prev;
    int          wait_cnt;
    int          pend_cnt;
    logic [31:0] hs_addr;
    logic [31:0] pend_addr;
    pend = 1'b0; hs_prev = 1'b0; wait_cnt = 0; pend_cnt = 0;
    hs_addr = 32'h0; pend_addr = 32'h0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = 32'h0;
      if (!auto_en) begin
        pend = 1'b0; hs_prev = 1'b0; wait_cnt = 0;
        bus.mem_rvalid_i = man_rvalid;
        bus.mem_rdata_i  = man_rdata;
      end else begin
        if (hs_prev) begin
          pend      = 1'b1;
          pend_cnt  = rv_wait;
          pend_addr = hs_addr;
          hs_prev   = 1'b0;
        end
        if (pend) begin
          if (pend_cnt == 0) begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = rdata_for(pend_addr);
            pend = 1'b0;
          end else begin
            pend_cnt--;
          end
        end else if (bus.mem_req_o) begin
          if (wait_cnt >= gnt_wait) begin
            bus.mem_gnt_i = 1'b1;
            hs_prev  = 1'b1;
            hs_addr  = bus.mem_addr_o;
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  // monitor: every grant / response valid consumes the next scoreboard entry
  initial begin
    forever begin
      @(negedge clk);
      if (bus.if_gnt_o)    sb_take(K_IF_GNT, bus.mem_addr_o);
      if (bus.dm_gnt_o)    sb_take(K_DM_GNT, bus.mem_addr_o);
      if (bus.if_rvalid_o) sb_take(K_IF_RV, bus.if_rdata_o);
      if (bus.dm_rvalid_o) sb_take(K_DM_RV, bus.dm_rdata_o);
      if (bus.mem_rvalid_i && !bus.if_rvalid_o) chk32("if_rdata_zero", bus.if_rdata_o, 32'h0);
      if (bus.mem_rvalid_i && !bus.dm_rvalid_o) chk32("dm_rdata_zero", bus.dm_rdata_o, 32'h0);
    end
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timeout");
  end

  // directed test sequence
  initial begin
    rst_n = 1'b0; bus.flush_i = 1'b0;
    auto_en = 1'b1; gnt_wait = 0; rv_wait = 0;
    man_rvalid = 1'b0; man_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk1("rst_mem_req", bus.mem_req_o, 1'b0);
    chk1("rst_if_rvalid", bus.if_rvalid_o, 1'b0);
    chk1("rst_dm_gnt", bus.dm_gnt_o, 1'b0);
    chk1("rst_hazard", bus.structural_hazard_o, 1'b0);
    @(posedge clk); #3 rst_n = 1'b1;

    // fetch alone, immediate grant, response next cycle
    @(negedge clk);
    fq.push_back(32'h0000_0100);
    expect_ev(K_IF_GNT, 32'h0000_0100);
    expect_ev(K_IF_RV, 32'hDEAD_BEEF);
    @(negedge clk);
    chk1("t029_if_gnt_c0", bus.if_gnt_o, 1'b1);
    chk1("t029_dm_gnt_c0", bus.dm_gnt_o, 1'b0);
    @(negedge clk);
    chk1("t029_if_rvalid_c1", bus.if_rvalid_o, 1'b1);
    chk32("t029_if_rdata_c1", bus.if_rdata_o, 32'hDEAD_BEEF);
    chk1("t029_dm_rvalid_c1", bus.dm_rvalid_o, 1'b0);
    wait_drain(50, "t029");

    // both request, data first, then fetch
    fq.push_back(32'h0000_0200);
    dq.push_back('{we: 1'b0, be: 4'hF, addr: 32'h0000_3000, wdata: 32'h0});
    expect_ev(K_DM_GNT, 32'h0000_3000);
    expect_ev(K_DM_RV, rdata_for(32'h0000_3000));
    expect_ev(K_IF_GNT, 32'h0000_0200);
    expect_ev(K_IF_RV, rdata_for(32'h0000_0200));
    @(negedge clk);
    chk1("t030_dm_gnt_c0", bus.dm_gnt_o, 1'b1);
    chk1("t030_hazard_c0", bus.structural_hazard_o, 1'b1);
    @(negedge clk);
    chk1("t030_dm_rvalid_c1", bus.dm_rvalid_o, 1'b1);
    chk1("t030_hazard_c1", bus.structural_hazard_o, 1'b0);
    @(negedge clk);
    chk1("t030_if_gnt_c2", bus.if_gnt_o, 1'b1);
    chk1("t030_hazard_c2", bus.structural_hazard_o, 1'b0);
    wait_drain(50, "t030");

    // starvation limit 2: D,D,F,D,D,F
    fq.push_back(32'h0000_1000);
    fq.push_back(32'h0000_1004);
    dq.push_back('{we: 1'b0, be: 4'hF, addr: 32'h0000_5000, wdata: 32'h0});
    dq.push_back('{we: 1'b0, be: 4'hF, addr: 32'h0000_5004, wdata: 32'h0});
    dq.push_back('{we: 1'b1, be: 4'hF, addr: 32'h0000_5008, wdata: 32'h1111_2222});
    dq.push_back('{we: 1'b0, be: 4'hF, addr: 32'h0000_500C, wdata: 32'h0});
    expect_ev(K_DM_GNT, 32'h0000_5000); expect_ev(K_DM_RV, rdata_for(32'h0000_5000));
    expect_ev(K_DM_GNT, 32'h0000_5004); expect_ev(K_DM_RV, rdata_for(32'h0000_5004));
    expect_ev(K_IF_GNT, 32'h0000_1000); expect_ev(K_IF_RV, rdata_for(32'h0000_1000));
    expect_ev(K_DM_GNT, 32'h0000_5008); expect_ev(K_DM_RV, rdata_for(32'h0000_5008));
    expect_ev(K_DM_GNT, 32'h0000_500C); expect_ev(K_DM_RV, rdata_for(32'h0000_500C));
    expect_ev(K_IF_GNT, 32'h0000_1004); expect_ev(K_IF_RV, rdata_for(32'h0000_1004));
    wait_drain(100, "t031");

    // data write stalled 3 cycles by memory; flush has no effect on data owner
    gnt_wait = 3;
    bus.flush_i = 1'b1;
    dq.push_back('{we: 1'b1, be: 4'b0011, addr: 32'h0000_2000, wdata: 32'h1234_5678});
    expect_ev(K_DM_GNT, 32'h0000_2000);
    expect_ev(K_DM_RV, rdata_for(32'h0000_2000));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("t032_mem_req", bus.mem_req_o, 1'b1);
      chk1("t032_mem_we", bus.mem_we_o, 1'b1);
      chk32("t032_mem_be", {28'h0, bus.mem_be_o}, 32'h0000_0003);
      chk32("t032_mem_addr", bus.mem_addr_o, 32'h0000_2000);
      chk32("t032_mem_wdata", bus.mem_wdata_o, 32'h1234_5678);
      chk1("t032_dm_gnt", bus.dm_gnt_o, (i == 3));
      chk1("t032_hazard", bus.structural_hazard_o, 1'b1);
    end
    @(negedge clk);
    chk1("t032_dm_rvalid", bus.dm_rvalid_o, 1'b1);
    wait_drain(50, "t032");
    bus.flush_i = 1'b0;
    gnt_wait = 0;

    // flush while fetch waits in RESP drops that response only
    rv_wait = 2;
    fq.push_back(32'h0000_0300);
    expect_ev(K_IF_GNT, 32'h0000_0300);
    @(negedge clk);
    chk1("t033_if_gnt", bus.if_gnt_o, 1'b1);
    @(posedge clk); #1 bus.flush_i = 1'b1;
    @(posedge clk); #1 bus.flush_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk1("t033_if_rvalid_dropped", bus.if_rvalid_o, 1'b0);
    wait_drain(50, "t033a");
    rv_wait = 0;
    fq.push_back(32'h0000_0304);
    expect_ev(K_IF_GNT, 32'h0000_0304);
    expect_ev(K_IF_RV, rdata_for(32'h0000_0304));
    wait_drain(50, "t033b");

    // reset in REQ clears outputs at once; stray response afterwards is ignored
    auto_en = 1'b0;
    man_rvalid = 1'b0;
    dq.push_back('{we: 1'b0, be: 4'hF, addr: 32'h0000_4000, wdata: 32'h0});
    @(negedge clk);
    chk1("t034_mem_req_idle", bus.mem_req_o, 1'b1);
    @(negedge clk);
    chk1("t034_mem_req_req", bus.mem_req_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("t034_rst_mem_req", bus.mem_req_o, 1'b0);
    chk1("t034_rst_dm_gnt", bus.dm_gnt_o, 1'b0);
    chk1("t034_rst_if_gnt", bus.if_gnt_o, 1'b0);
    chk1("t034_rst_hazard", bus.structural_hazard_o, 1'b0);
    chk32("t034_rst_dm_rdata", bus.dm_rdata_o, 32'h0);
    dq.delete();
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1 man_rvalid = 1'b1; man_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk1("t034_stray_dm_rvalid", bus.dm_rvalid_o, 1'b0);
    chk1("t034_stray_if_rvalid", bus.if_rvalid_o, 1'b0);
    @(posedge clk); #1 man_rvalid = 1'b0; man_rdata = 32'h0;
    @(negedge clk);
    auto_en = 1'b1;
    fq.push_back(32'h0000_0500);
    expect_ev(K_IF_GNT, 32'h0000_0500);
    expect_ev(K_IF_RV, rdata_for(32'h0000_0500));
    wait_drain(50, "t034");

    chk32("sb_empty", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
